// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver. Synchronises and deglitches the pad
// lines, deserialises 11-bit frames, folds E0/F0 prefixes into one event per
// key action and queues events in a small FIFO behind a valid/ready handshake.
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic [7:0]    flt_cnt;
    logic          clk_flt, clk_flt_d;
    logic          fe;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          byte_vld;
    logic [7:0]    shreg;
    logic          par_ok;
    logic          ext_pend, brk_pend;
    logic          is_e0, is_f0, push;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_ok;
    logic [9:0]    head;

    // Two-flop synchronisers; pad lines idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt   <= 8'd0;
            clk_flt   <= 1'b1;
            clk_flt_d <= 1'b1;
        end else begin
            clk_flt_d <= clk_flt;
            if (clk_s2 == clk_flt) begin
                flt_cnt <= 8'd0;
            end else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
                flt_cnt <= 8'd0;
                clk_flt <= clk_s2;
            end else begin
                flt_cnt <= flt_cnt + 8'd1;
            end
        end
    end

    assign fe     = clk_flt_d & ~clk_flt;
    assign to_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy   = (state != IDLE);

    // Frame FSM with inactivity timeout; a timeout wins over a coincident edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (to_hit) begin
                state     <= IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                if (state == IDLE || fe)
                    to_cnt <= '0;
                else
                    to_cnt <= to_cnt + 1'b1;
                if (fe) begin
                    case (state)
                        IDLE: begin
                            if (!data_s2) begin
                                state   <= DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                        DATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= PARITY;
                        end
                        PARITY: state <= STOP;
                        STOP: begin
                            state <= IDLE;
                            if (par_ok && data_s2)
                                byte_vld <= 1'b1;
                            else
                                frame_err <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // Shift register and parity verdict; shreg holds the byte until the next frame's first data bit
    always_ff @(posedge clk) begin
        if (fe && state == DATA)
            shreg <= {data_s2, shreg[7:1]};
        if (fe && state == PARITY)
            par_ok <= ^shreg ^ data_s2;
    end

    assign is_e0 = (shreg == 8'hE0);
    assign is_f0 = (shreg == 8'hF0);
    assign push  = byte_vld && !is_e0 && !is_f0;

    // Prefix folding; any frame error discards a half-built prefix sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_vld) begin
            if (is_e0) begin
                ext_pend <= 1'b1;
            end else if (is_f0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    assign evt_valid = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign wr_ok     = push && (!full || pop);

    // Event storage; a full FIFO still accepts a push when the head leaves the same cycle
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {ext_pend, brk_pend, shreg};
    end

    // FIFO pointers, occupancy and drop indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)
                count <= count + 1'b1;
            else if (!wr_ok && pop)
                count <= count - 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign evt_code    = evt_valid ? head[7:0] : 8'd0;
    assign evt_release = evt_valid & head[8];
    assign evt_ext     = evt_valid & head[9];

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: drives PS/2 frames into ps2_scan_rx and compares delivered
// events, error and overflow pulses against a byte-level model of the protocol.
module tb_ps2_scan_rx;

    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int DEP  = 4;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    ps2_scan_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (DEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_release(evt_release),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-level protocol model: expected events {ext, release, code}
    logic [9:0] exp_q[$];
    bit         m_ext = 1'b0;
    bit         m_rel = 1'b0;
    int         exp_err = 0;
    int         exp_ovf = 0;
    int         err_cnt = 0;
    int         ovf_cnt = 0;
    logic [9:0] mon_e;

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            if (exp_q.size() >= DEP)
                exp_ovf++;
            else
                exp_q.push_back({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endfunction

    // Consumer: 0 = stalled, 1 = always ready, 2 = random
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       evt_ready = 1'b1;
                2:       evt_ready = 1'($urandom_range(0, 1));
                default: evt_ready = 1'b0;
            endcase
        end
    end

    // Monitor: score every accepted event and count pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_cnt++;
            if (overflow)  ovf_cnt++;
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", 32'(evt_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("evt", 32'({evt_ext, evt_release, evt_code}), 32'(mon_e));
                end
            end
        end
    end

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_byte(b, !(bad_par || bad_stop));
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] b;
    logic [7:0] code;
    bit         busy_seen;
    bit         do_ext, do_rel, bad;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        rst_n    = 1'b1;
        rdy_mode = 1;
        repeat (4) @(posedge clk);

        // Single make code with latency check on the stop-bit edge
        b = 8'h1C;
        model_byte(b, 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (FL + 3) @(posedge clk);
        @(negedge clk);
        chk("lat_early", 32'(evt_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", 32'(evt_valid), 32'd1);
        chk("lat_ferr", 32'(frame_err), 32'd0);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);

        // Prefix folding
        send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
        send(8'hE0, 0, 0); send(8'h75, 0, 0);
        // Parity error after E0 clears the prefix
        send(8'hE0, 0, 0); send(8'h16, 1, 0); send(8'h75, 0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("prefix_left", 32'(exp_q.size()), 32'd0);
        chk("prefix_err", 32'(err_cnt), 32'(exp_err));

        // Randomised key actions with random consumer stalls and bad frames
        rdy_mode = 2;
        for (int n = 0; n < 16; n++) begin
            do code = 8'($urandom_range(0, 255)); while (code == 8'hE0 || code == 8'hF0);
            do_ext = 1'($urandom_range(0, 1));
            do_rel = 1'($urandom_range(0, 1));
            bad    = ($urandom_range(0, 5) == 0);
            if (do_ext) send(8'hE0, 0, 0);
            if (do_rel) send(8'hF0, 0, 0);
            if (bad && $urandom_range(0, 1) == 1) send(code, 0, 1);
            else                                  send(code, bad, 0);
        end
        rdy_mode = 1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("rand_left", 32'(exp_q.size()), 32'd0);
        chk("rand_err", 32'(err_cnt), 32'(exp_err));

        // Overflow with a stalled consumer, then drain one per cycle
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        send(8'h16, 0, 0); send(8'h1E, 0, 0); send(8'h26, 0, 0);
        send(8'h25, 0, 0); send(8'h2E, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
        chk("full_valid", 32'(evt_valid), 32'd1);
        chk("full_head", 32'(evt_code), 32'h16);
        @(posedge clk);
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_valid", 32'(evt_valid), 32'd0);
        chk("drain_left", 32'(exp_q.size()), 32'd0);

        // Short low glitch on ps2_clk in IDLE, with data low, must not start a frame
        ps2_data = 1'b0;
        @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (FL - 1) @(posedge clk);
        #1 ps2_clk = 1'b1;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        chk("glitch_busy", 32'(busy_seen), 32'd0);
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);

        // Timeout after four data bits
        model_byte(8'h00, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        for (int k = 1; k <= FL + 2 + TO; k++) begin
            @(posedge clk);
            if (k == HALF) #1 ps2_clk = 1'b1;
        end
        @(negedge clk);
        chk("to_early", 32'(frame_err), 32'd0);
        chk("to_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("to_pulse", 32'(frame_err), 32'd1);
        chk("to_busy_after", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("to_pulse_end", 32'(frame_err), 32'd0);
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        send(8'h1C, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("to_recover_left", 32'(exp_q.size()), 32'd0);
        chk("to_err", 32'(err_cnt), 32'(exp_err));

        // Asynchronous reset in the middle of a frame with an event pending
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        send(8'h2E, 0, 0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(evt_valid), 32'd0);
        exp_q.delete();
        m_ext = 1'b0;
        m_rel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("ovf_final", 32'(ovf_cnt), 32'(exp_ovf));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
